// File: rtl/tile_write_scheduler_pkg.sv
// Shared types and constants for the tile write scheduler: tile-map bounds,
// command opcodes, the queued request record and the issue FSM states.
package tile_pkg;

    localparam int TILE_COLS = 40;
    localparam int TILE_ROWS = 30;

    localparam logic [3:0] OP_IDLE       = 4'h0;
    localparam logic [3:0] OP_TILE_WRITE = 4'h2;

    typedef struct packed {
        logic [5:0] row;
        logic [5:0] col;
        logic [7:0] tile;
    } tile_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP
    } sched_state_e;

    function automatic logic [31:0] tile_cmd(input tile_req_t r);
        return {OP_TILE_WRITE, r.col, r.row, 8'h00, r.tile};
    endfunction

endpackage

// File: rtl/tile_write_scheduler_if.sv
// Request/command bundle between the two tile requesters and the scheduler;
// master = requester/host side, slave = scheduler side.
interface tile_write_scheduler_if #(
    parameter int FIFO_DEPTH = 8
);
    logic [1:0]                    req_valid;
    logic [1:0]                    req_ready;
    logic [1:0][5:0]               req_row;
    logic [1:0][5:0]               req_col;
    logic [1:0][7:0]               req_tile;
    logic                          vblank;
    logic [31:0]                   control;
    logic                          busy;
    logic                          drop_err;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport master (
        output req_valid, req_row, req_col, req_tile, vblank,
        input  req_ready, control, busy, drop_err, fifo_count
    );

    modport slave (
        input  req_valid, req_row, req_col, req_tile, vblank,
        output req_ready, control, busy, drop_err, fifo_count
    );

endinterface

// File: rtl/tile_write_scheduler_fifo.sv
// Synchronous FIFO of tile_req_t; head is read combinationally, push when full
// and pop when empty are ignored.
module tile_req_fifo
    import tile_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  tile_req_t                wdata,
    output tile_req_t                rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    tile_req_t        r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rdata   = r_mem[r_rptr];
    assign w_push  = push & ~full;
    assign w_pop   = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end

endmodule

// File: rtl/tile_write_scheduler.sv
// Round-robin two-requester tile write scheduler feeding the color mapper control word.
// Define TILE_SCHED_VBLANK_ONLY_EN to start new writes only while vblank is high.
module tile_write_scheduler
    import tile_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    tile_write_scheduler_if.slave   bus
);
    localparam int          HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [31:0] IDLE_WORD = {OP_IDLE, 28'h0};

    sched_state_e                 r_state, w_state_nxt;
    logic [31:0]                  r_control, w_control_nxt;
    logic [HW-1:0]                r_hold, w_hold_nxt;
    logic                         r_ptr;
    logic                         r_drop_err;
    logic [1:0]                   w_grant;
    logic [1:0]                   w_accept;
    logic                         w_sel;
    logic                         w_legal;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_gate;
    tile_req_t                    w_req;
    tile_req_t                    w_head;
    logic [$clog2(FIFO_DEPTH):0]  w_count;

    // Lone requester always wins; contention goes to the priority pointer.
    always_comb begin
        w_grant = bus.req_valid;
        if (bus.req_valid == 2'b11) begin
            w_grant        = 2'b00;
            w_grant[r_ptr] = 1'b1;
        end
    end

    assign bus.req_ready = (reset_n && !w_full) ? w_grant : 2'b00;
    assign w_accept      = bus.req_valid & bus.req_ready;
    assign w_sel         = w_accept[1];
    assign w_req         = '{row: bus.req_row[w_sel], col: bus.req_col[w_sel], tile: bus.req_tile[w_sel]};
    assign w_legal       = (w_req.row < 6'(TILE_ROWS)) && (w_req.col < 6'(TILE_COLS));
    assign w_push        = (|w_accept) && w_legal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            r_drop_err <= (|w_accept) && !w_legal;
            if (|w_accept) r_ptr <= ~w_sel;
        end
    end

    tile_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .wdata   (w_req),
        .rdata   (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

`ifdef TILE_SCHED_VBLANK_ONLY_EN
    assign w_gate = bus.vblank;
`else
    logic w_unused_vblank;
    assign w_unused_vblank = bus.vblank;
    assign w_gate          = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_control <= IDLE_WORD;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_control <= w_control_nxt;
            r_hold    <= w_hold_nxt;
        end
    end

    // The gate only blocks starting a write; one already in ISSUE runs to completion.
    always_comb begin
        w_state_nxt   = r_state;
        w_control_nxt = r_control;
        w_hold_nxt    = r_hold;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && w_gate) begin
                    w_pop         = 1'b1;
                    w_control_nxt = tile_cmd(w_head);
                    w_hold_nxt    = HW'(1);
                    w_state_nxt   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_hold == HW'(HOLD_CYCLES)) begin
                    w_control_nxt = IDLE_WORD;
                    w_state_nxt   = ST_GAP;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            ST_GAP: begin
                w_control_nxt = IDLE_WORD;
                w_state_nxt   = ST_IDLE;
                if (!w_empty && w_gate) begin
                    w_pop         = 1'b1;
                    w_control_nxt = tile_cmd(w_head);
                    w_hold_nxt    = HW'(1);
                    w_state_nxt   = ST_ISSUE;
                end
            end
            default: begin
                w_control_nxt = IDLE_WORD;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    assign bus.control    = r_control;
    assign bus.busy       = !w_empty || (r_state != ST_IDLE);
    assign bus.drop_err   = r_drop_err;
    assign bus.fifo_count = w_count;

endmodule
